// File: rtl/shift_pkg.sv
// Shared types and constants for the shift-register family (TX and RX ends).
package shift_pkg;

  // Transmitter control states.
  typedef enum logic [0:0] {
    TX_IDLE  = 1'b0,
    TX_SHIFT = 1'b1
  } tx_state_t;

  // Bit-order select, latched with each word.
  localparam logic DIR_MSB_FIRST = 1'b0;  // shift left, Q = MSB
  localparam logic DIR_LSB_FIRST = 1'b1;  // shift right, Q = LSB

  // Shift register operation; the serial-in receiver uses the same encoding.
  typedef enum logic [1:0] {
    SR_HOLD  = 2'b00,
    SR_LOAD  = 2'b01,
    SR_LEFT  = 2'b10,
    SR_RIGHT = 2'b11
  } sr_mode_t;

  // Next shift-register value for a given mode; vacated positions fill with 0.
  function automatic logic [63:0] sr_next(input sr_mode_t mode, input logic [63:0] cur,
                                          input logic [63:0] load, input int width);
    logic [63:0] res;
    logic [63:0] mask;
    mask = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    case (mode)
      SR_LOAD:  res = load;
      SR_LEFT:  res = cur << 1;
      SR_RIGHT: res = (cur & mask) >> 1;
      default:  res = cur;
    endcase
    return res & mask;
  endfunction

endpackage

// File: rtl/piso_tx_bit_counter.sv
// Modulo-WIDTH bit counter; last flags the final bit position.
module bit_counter #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  output logic [$clog2(WIDTH)-1:0] count,
  output logic                     last
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_VAL = CW'(WIDTH - 1);

  assign last = (count == LAST_VAL);

  // Clear has priority over count; wraps to 0 after the last position.
  always_ff @(posedge clk) begin
    if (rst)      count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= last ? '0 : count + 1'b1;
  end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter: valid/ready word intake, tick-paced
// serial output, MSB- or LSB-first, one mandatory idle cycle between words.
module piso_tx
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] par_i,
  input  logic             dir_i,
  input  logic             tick_i,
  output logic             Q,
  output logic             frame_o,
  output logic             done_o
);

  localparam int CW = $clog2(WIDTH);

  tx_state_t        state_q, state_d;
  sr_mode_t         sr_mode;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic [63:0]      sr_wide;
  logic             dir_q;
  logic             done_q;
  logic             last_tick;
  logic             cnt_clr;
  logic             cnt_en;
  logic [CW-1:0]    cnt;
  logic             cnt_last;

  bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (cnt),
    .last  (cnt_last)
  );

  // Next state, handshake and datapath control; tick is only honoured in SHIFT.
  always_comb begin
    state_d   = state_q;
    ready_o   = 1'b0;
    frame_o   = 1'b0;
    sr_mode   = SR_HOLD;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    last_tick = 1'b0;
    case (state_q)
      TX_IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          state_d = TX_SHIFT;
          sr_mode = SR_LOAD;
          cnt_clr = 1'b1;
        end
      end
      TX_SHIFT: begin
        frame_o = 1'b1;
        if (tick_i) begin
          if (cnt_last) begin
            // Final bit consumed; register contents are don't-care in IDLE.
            state_d   = TX_IDLE;
            last_tick = 1'b1;
            cnt_clr   = 1'b1;
          end else begin
            sr_mode = (dir_q == DIR_LSB_FIRST) ? SR_RIGHT : SR_LEFT;
            cnt_en  = 1'b1;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // Shift register next value through the shared mode decoder.
  always_comb begin
    sr_wide = sr_next(sr_mode, 64'(shreg_q), 64'(par_i), WIDTH);
    shreg_d = sr_wide[WIDTH-1:0];
  end

  // State and done pulse; reset beats a simultaneous accept or last tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TX_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= last_tick;
    end
  end

  // Word and bit order are captured only on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
      dir_q   <= DIR_MSB_FIRST;
    end else begin
      shreg_q <= shreg_d;
      if (sr_mode == SR_LOAD) dir_q <= dir_i;
    end
  end

  // Serial output comes straight from registers, forced low outside a frame.
  assign Q      = (state_q == TX_SHIFT) &&
                  ((dir_q == DIR_LSB_FIRST) ? shreg_q[0] : shreg_q[WIDTH-1]);
  assign done_o = done_q;

endmodule

// File: tb/tb_piso_tx.sv
// Scoreboard bench for piso_tx: stimulus queues the expected serial stream,
// a negedge monitor checks Q/frame/ready/done every cycle.
module tb_piso_tx;
  import shift_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] par_i;
  logic       dir_i;
  logic       tick_i;
  logic       Q;
  logic       frame_o;
  logic       done_o;

  piso_tx #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .par_i(par_i), .dir_i(dir_i), .tick_i(tick_i),
    .Q(Q), .frame_o(frame_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  int   tests = 0;
  int   errors = 0;
  int   cyc = 0;
  int   tick_per = 1;
  int   done_cnt = 0;
  int   frame_cyc = 0;
  int   last_done_cyc = 0;
  int   idx = 0;
  bit   exp_done = 1'b0;
  logic bq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock; inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    tick_i = (tick_per <= 1) ? 1'b1 : ((cyc % tick_per) == 0);
  endtask

  // Queue a stream given in emission order, first bit at [7].
  task automatic push_stream(input logic [7:0] s);
    for (int i = 7; i >= 0; i--) bq.push_back(s[i]);
  endtask

  // Present a word and return the cycle number that follows its accept edge.
  task automatic offer(input logic [7:0] p, input logic d, input bit keep, output int acc);
    int n;
    valid_i = 1'b1; par_i = p; dir_i = d;
    n = 0;
    while (!ready_o && n < 100) begin step(); n++; end
    if (n >= 100) chk("accept_timeout", 32'(n), 32'd0);
    step();
    acc = cyc;
    if (!keep) valid_i = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 300) begin step(); n++; end
    chk("done_wait", 32'(done_cnt >= target), 32'd1);
  endtask

  // Monitor: compare outputs each cycle against the scoreboard queue.
  always @(negedge clk) begin
    chk("done_o", 32'(done_o), 32'(exp_done));
    exp_done = 1'b0;
    if (done_o) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    if (!frame_o) begin
      chk("idle_Q", 32'(Q), 32'd0);
      chk("idle_ready", 32'(ready_o), 32'd1);
    end else begin
      frame_cyc++;
      chk("busy_ready", 32'(ready_o), 32'd0);
      if (bq.size() == 0) begin
        chk("unexpected_frame", 32'd1, 32'd0);
      end else begin
        chk("serial_Q", 32'(Q), 32'(bq[0]));
        if (tick_i) begin
          void'(bq.pop_front());
          idx++;
          if (idx == 8) begin
            idx = 0;
            exp_done = 1'b1;
          end
        end
      end
    end
    if (rst) begin
      bq.delete();
      idx = 0;
      exp_done = 1'b0;
    end
  end

  initial begin
    int a1, a2, d0, f0;
    rst = 1'b1; valid_i = 1'b0; par_i = '0; dir_i = 1'b0; tick_i = 1'b1;
    // Reset held two cycles with tick high, then idle.
    step(); step();
    rst = 1'b0;
    repeat (3) step();
    chk("reset_no_done", 32'(done_cnt), 32'd0);

    // A5 MSB first at full rate.
    d0 = done_cnt; f0 = frame_cyc;
    push_stream(8'b1010_0101);
    offer(8'hA5, DIR_MSB_FIRST, 1'b0, a1);
    wait_done(d0 + 1);
    chk("a5_frame_cycles", 32'(frame_cyc - f0), 32'd8);
    chk("a5_done_cycle", 32'(last_done_cyc - a1), 32'd8);
    step();

    // 3C LSB first with a tick every third cycle.
    tick_per = 3;
    d0 = done_cnt;
    push_stream(8'b0011_1100);
    offer(8'h3C, DIR_LSB_FIRST, 1'b0, a1);
    wait_done(d0 + 1);
    repeat (5) step();
    chk("sparse_one_done", 32'(done_cnt - d0), 32'd1);
    tick_per = 1;

    // Back-to-back FF then 00 with valid held.
    d0 = done_cnt; f0 = frame_cyc;
    push_stream(8'hFF);
    push_stream(8'h00);
    offer(8'hFF, DIR_MSB_FIRST, 1'b1, a1);
    offer(8'h00, DIR_MSB_FIRST, 1'b0, a2);
    chk("b2b_accept_gap", 32'(a2 - a1), 32'd9);
    wait_done(d0 + 2);
    chk("b2b_frame_cycles", 32'(frame_cyc - f0), 32'd16);
    step();

    // F0 with mid-word input changes, then reset at bit 5.
    push_stream(8'b1111_0000);
    offer(8'hF0, DIR_MSB_FIRST, 1'b0, a1);
    step(); step();
    par_i = 8'h0F; dir_i = DIR_LSB_FIRST; valid_i = 1'b1;
    step();
    valid_i = 1'b0; par_i = '0; dir_i = DIR_MSB_FIRST;
    step();
    d0 = done_cnt;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_frame_low", 32'(frame_o), 32'd0);
    chk("rst_ready_high", 32'(ready_o), 32'd1);
    repeat (3) step();
    chk("rst_no_done", 32'(done_cnt - d0), 32'd0);

    // Clean word after the abandoned one.
    push_stream(8'b0101_1010);
    offer(8'h5A, DIR_MSB_FIRST, 1'b0, a1);
    wait_done(d0 + 1);
    step();

    // 81 accepted with tick high in the accept cycle.
    d0 = done_cnt; f0 = frame_cyc;
    push_stream(8'b1000_0001);
    offer(8'h81, DIR_MSB_FIRST, 1'b0, a1);
    wait_done(d0 + 1);
    chk("t81_frame_cycles", 32'(frame_cyc - f0), 32'd8);
    chk("t81_done_cycle", 32'(last_done_cyc - a1), 32'd8);
    repeat (2) step();

    chk("scoreboard_empty", 32'(bq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
# piso_tx

Parallel-in/serial-out transmitter for the shift-register family: accepts a WIDTH-bit word over a valid/ready handshake and drives it onto a single serial line one bit per shift tick, MSB-first or LSB-first. It is the transmit end that feeds a serial-in shift register; the register's D input connects directly to this block's `Q`. Pacing comes from an external tick, so the same block serves full-rate and slow serial links.

## Interface
Parameters:
- `WIDTH`, default 8: word width in bits; must be ≥ 2.

Ports:
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `valid_i`  input  1  `par_i` holds a word to send.
- `ready_o`  output  1  block can accept a word this cycle.
- `par_i`  input  WIDTH  parallel word; sampled only on accept.
- `dir_i`  input  1  bit order: 0 = MSB first (shift left), 1 = LSB first (shift right); sampled only on accept.
- `tick_i`  input  1  shift enable; advances one bit when high in SHIFT.
- `Q`  output  1  serial data out.
- `frame_o`  output  1  high while a word's bits are on `Q`.
- `done_o`  output  1  one-cycle pulse after the last bit has been consumed.

## Operation
- States: IDLE, SHIFT.
- Reset: state IDLE, shift register 0, bit counter 0, latched dir 0; outputs `ready_o`=1, `Q`=0, `frame_o`=0, `done_o`=0.
- IDLE: `ready_o`=1, `Q`=0, `frame_o`=0. `tick_i` ignored. Accept = `valid_i` && `ready_o`: load shift register with `par_i`, latch `dir_i`, counter←0, go to SHIFT.
- SHIFT: `ready_o`=0, `frame_o`=1. `Q` = shreg[WIDTH-1] if latched dir=0, else shreg[0]. `Q` is a pure function of registers (no combinational path from inputs).
  - `tick_i`=1 and counter < WIDTH-1: shift toward the output end (left for dir 0, right for dir 1), fill with 0, counter++.
  - `tick_i`=1 and counter = WIDTH-1: go to IDLE; `done_o`=1 on the next cycle only.
  - `tick_i`=0: hold everything.
- Counter width is $clog2(WIDTH); it never exceeds WIDTH-1.
- `valid_i`, `par_i`, and `dir_i` changes during SHIFT have no effect. A word presented while `ready_o`=0 waits; the sender holds `valid_i` until accepted.
- `tick_i` in the accept cycle is ignored; the first bit is always driven for at least one cycle.
- `rst` mid-word: the word is abandoned, the next cycle is in IDLE with reset outputs, and no `done_o` pulse is produced.
- `rst` and accept in the same cycle: reset wins, and the word is not taken.

## Timing
- Accept at edge 0 → first bit on `Q`, `frame_o`=1 from cycle 1.
- Bit k stays on `Q` from the cycle after the (k-1)th consumed tick through the cycle of the kth tick, inclusive.
- With `tick_i` tied high: bits in cycles 1..WIDTH; `done_o`=1 and `ready_o`=1 in cycle WIDTH+1. Earliest re-accept is at the end of cycle WIDTH+1, so back-to-back throughput is one word per WIDTH+1 cycles. The one IDLE gap cycle is mandatory.
- `done_o` coincides with the first IDLE cycle and may coincide with a new accept.

## Structure
- Shared package `shift_pkg`:
  - `typedef enum logic [0:0] {TX_IDLE, TX_SHIFT} tx_state_t`
  - constants `DIR_MSB_FIRST` = 1'b0 and `DIR_LSB_FIRST` = 1'b1
  - the shift register's 2-bit mode encoding (HOLD/LOAD/LEFT/RIGHT), so TX and RX benches share it.
- One sub-module, `bit_counter`: parameterized modulo counter with `clk`, `rst`, `clr`, `en`, `count`, and `last` (count = WIDTH-1). The FSM and shift datapath stay in `piso_tx`.

## Test plan
- Reset, then idle: `rst` high 2 cycles, `valid_i`=0, `tick_i`=1 → `ready_o`=1, `Q`=0, `frame_o`=0, `done_o`=0 throughout.
- MSB first at full rate: `par_i`=8'hA5, `dir_i`=0, `tick_i`=1 → `Q` = 1,0,1,0,0,1,0,1 in cycles 1–8; `done_o` only in cycle 9; `ready_o`=0 in cycles 1–8.
- LSB first with sparse ticks: `par_i`=8'h3C, `dir_i`=1, `tick_i` every 3rd cycle → `Q` = 0,0,1,1,1,1,0,0, each bit held until its tick; exactly one `done_o`.
- Back-to-back words: `valid_i` held high with 8'hFF then 8'h00 → second accept in cycle 9; `Q` = eight 1s, one 0 (IDLE gap), then eight 0s with `frame_o` high; two `done_o` pulses.
- Mid-word interference: change `par_i` and `dir_i` and pulse `valid_i` during bit 3 of 8'hF0 → serial output unchanged. Then assert `rst` at bit 5 → IDLE outputs next cycle, no `done_o`, and the next word sends cleanly.
- Tick in accept cycle: accept 8'h81 with `tick_i`=1 in that cycle → first bit still lasts one full cycle; total 8 bit-cycles.
